// File: rtl/haru_axis_pkg.sv
// Shared definitions for the AXI-Stream return-path blocks:
// default widths, scheduler state type and grant-index width helper.
package haru_axis_pkg;

  localparam int unsigned DEF_AXIS_DATA_WIDTH = 32;
  localparam int unsigned DEF_FIFO_DATA_WIDTH = 32;
  localparam int unsigned DEF_AXIS_DEST_WIDTH = 4;
  localparam int unsigned DEF_NUM_FIFOS       = 2;
  localparam int unsigned DEF_PKT_LEN_WIDTH   = 16;

  // Packet scheduler states; encodings fixed for compatibility with existing dumps.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Bits needed to hold an index in [0, n-1]; never less than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned p = 2; p < n; p = p << 1) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr,
// wrapping around. Produces one-hot grant, its index and a valid flag.
module rr_arbiter #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant_onehot,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);

  logic [IW-1:0] pos;

  // Scan requesters starting at ptr; the first hit wins.
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    grant_valid  = 1'b0;
    pos          = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = IW'((32'(ptr) + k) % N);
      if (!grant_valid && req[pos]) begin
        grant_valid       = 1'b1;
        grant_idx         = pos;
        grant_onehot[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/s2mm_packet_arbiter.sv
// Return-path scheduler: shares one AXI-Stream S2MM port between several
// FWFT result FIFOs. Round-robin at packet granularity, fixed-length
// packets tagged with tdest = channel index and tlast on the final word.
module s2mm_packet_arbiter
  import haru_axis_pkg::*;
#(
  parameter int unsigned AXIS_DATA_WIDTH = DEF_AXIS_DATA_WIDTH,
  parameter int unsigned FIFO_DATA_WIDTH = DEF_FIFO_DATA_WIDTH,
  parameter int unsigned AXIS_DEST_WIDTH = DEF_AXIS_DEST_WIDTH,
  parameter int unsigned NUM_FIFOS       = DEF_NUM_FIFOS,
  parameter int unsigned PKT_LEN_WIDTH   = DEF_PKT_LEN_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic [NUM_FIFOS-1:0]                 chan_en,
  input  logic [PKT_LEN_WIDTH-1:0]             cfg_pkt_len,
  input  logic [NUM_FIFOS-1:0]                 fifo_empty,
  input  logic [NUM_FIFOS*FIFO_DATA_WIDTH-1:0] fifo_data,
  output logic [NUM_FIFOS-1:0]                 fifo_rden,
  output logic [AXIS_DATA_WIDTH-1:0]           DST_AXIS_tdata,
  output logic [AXIS_DEST_WIDTH-1:0]           DST_AXIS_tdest,
  output logic                                 DST_AXIS_tlast,
  output logic                                 DST_AXIS_tvalid,
  input  logic                                 DST_AXIS_tready,
  output logic                                 busy
);

  localparam int unsigned IW = idx_width(NUM_FIFOS);

  state_t                     state;
  logic [NUM_FIFOS-1:0]       req;
  logic [NUM_FIFOS-1:0]       arb_onehot;
  logic [IW-1:0]              arb_idx;
  logic                       arb_valid;
  logic [NUM_FIFOS-1:0]       grant_onehot;
  logic [IW-1:0]              grant_idx;
  logic [IW-1:0]              rr_ptr;
  logic [PKT_LEN_WIDTH-1:0]   cnt;
  logic [FIFO_DATA_WIDTH-1:0] head;
  logic                       pop;

  assign req = chan_en & ~fifo_empty;

  rr_arbiter #(
    .N  (NUM_FIFOS),
    .IW (IW)
  ) u_rr_arbiter (
    .req          (req),
    .ptr          (rr_ptr),
    .grant_onehot (arb_onehot),
    .grant_idx    (arb_idx),
    .grant_valid  (arb_valid)
  );

  // FWFT head of the granted FIFO.
  always_comb begin
    head = '0;
    for (int unsigned i = 0; i < NUM_FIFOS; i++) begin
      if (grant_idx == IW'(i)) begin
        head = fifo_data[i*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH];
      end
    end
  end

  // Pop only while streaming, the granted FIFO has data and the output slot is free.
  assign pop       = (state == STREAM) && |(grant_onehot & ~fifo_empty) &&
                     (!DST_AXIS_tvalid || DST_AXIS_tready);
  assign fifo_rden = pop ? grant_onehot : '0;
  assign busy      = (state == STREAM) || DST_AXIS_tvalid;

  // Packet FSM: arbitrate in IDLE, count words of the granted packet in STREAM.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      grant_idx    <= '0;
      grant_onehot <= '0;
      rr_ptr       <= '0;
      cnt          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_valid) begin
            grant_idx    <= arb_idx;
            grant_onehot <= arb_onehot;
            cnt          <= (cfg_pkt_len == '0) ? '0 : cfg_pkt_len - 1'b1;
            rr_ptr       <= (arb_idx == IW'(NUM_FIFOS - 1)) ? '0 : arb_idx + 1'b1;
            state        <= STREAM;
          end
        end
        STREAM: begin
          if (pop) begin
            if (cnt == '0) begin
              state <= IDLE;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Single-entry output register; loads on pop, clears when accepted without refill.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      DST_AXIS_tdata  <= '0;
      DST_AXIS_tdest  <= '0;
      DST_AXIS_tlast  <= 1'b0;
      DST_AXIS_tvalid <= 1'b0;
    end else if (pop) begin
      DST_AXIS_tdata  <= AXIS_DATA_WIDTH'(head);
      DST_AXIS_tdest  <= AXIS_DEST_WIDTH'(grant_idx);
      DST_AXIS_tlast  <= (cnt == '0);
      DST_AXIS_tvalid <= 1'b1;
    end else if (DST_AXIS_tvalid && DST_AXIS_tready) begin
      DST_AXIS_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_s2mm_packet_arbiter.sv
// Bench for s2mm_packet_arbiter: FWFT FIFOs modelled as queues, expected
// beat stream produced by a packet-level round-robin model.
module tb_s2mm_packet_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  chan_en;
  logic [15:0] cfg_pkt_len;
  logic [1:0]  fifo_empty;
  logic [63:0] fifo_data;
  logic [1:0]  fifo_rden;
  logic [31:0] tdata;
  logic [3:0]  tdest;
  logic        tlast, tvalid, tready, busy;

  always #5 clk = ~clk;

  s2mm_packet_arbiter #(
    .AXIS_DATA_WIDTH (32),
    .FIFO_DATA_WIDTH (32),
    .AXIS_DEST_WIDTH (4),
    .NUM_FIFOS       (2),
    .PKT_LEN_WIDTH   (16)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .chan_en         (chan_en),
    .cfg_pkt_len     (cfg_pkt_len),
    .fifo_empty      (fifo_empty),
    .fifo_data       (fifo_data),
    .fifo_rden       (fifo_rden),
    .DST_AXIS_tdata  (tdata),
    .DST_AXIS_tdest  (tdest),
    .DST_AXIS_tlast  (tlast),
    .DST_AXIS_tvalid (tvalid),
    .DST_AXIS_tready (tready),
    .busy            (busy)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  dest;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] fq0[$], fq1[$], m0[$], m1[$], hold0[$];
  int unsigned model_ptr = 0;
  int          errors = 0, checks = 0;
  bit          sb_en = 1'b1;
  int          hs_count = 0, hs_mark = 0, cyc = 0, first_hs = 0, last_hs = 0;
  int          rden0_cnt = 0, rden1_cnt = 0;
  logic        prev_stall = 1'b0;
  beat_t       prev_beat;
  logic [1:0]  rden_cap;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic refresh_fifo();
    fifo_empty[0]    = (fq0.size() == 0);
    fifo_empty[1]    = (fq1.size() == 0);
    fifo_data[31:0]  = (fq0.size() != 0) ? fq0[0] : 32'h0;
    fifo_data[63:32] = (fq1.size() != 0) ? fq1[0] : 32'h0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Random words go to the model source lists and either straight into the FIFO or a holding list.
  task automatic add(input int ch, input int n, input bit to_fifo);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      if (ch == 0) begin
        m0.push_back(w);
        if (to_fifo) fq0.push_back(w); else hold0.push_back(w);
      end else begin
        m1.push_back(w);
        fq1.push_back(w);
      end
    end
  endtask

  // Packet-level reference: serve channels with data round-robin, whole packets at a time.
  task automatic schedule(input int len, input logic [1:0] en);
    int    eff;
    int    c;
    beat_t b;
    eff = (len == 0) ? 1 : len;
    while (1) begin
      c = -1;
      for (int k = 0; k < 2; k++) begin
        int cc;
        cc = int'((model_ptr + k) % 2);
        if (c < 0 && en[cc] && ((cc == 0) ? m0.size() : m1.size()) > 0) c = cc;
      end
      if (c < 0) break;
      for (int j = 0; j < eff; j++) begin
        b.data = (c == 0) ? m0.pop_front() : m1.pop_front();
        b.dest = 4'(c);
        b.last = (j == eff - 1);
        exp_q.push_back(b);
      end
      model_ptr = (c + 1) % 2;
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk("drain_remaining", exp_q.size(), 0);
    repeat (2) step();
    chk("idle_busy", busy, 1'b0);
    chk("idle_tvalid", tvalid, 1'b0);
  endtask

  // FIFO side: pop the queue the DUT strobed at the edge, then present the new head.
  always begin
    @(posedge clk);
    rden_cap = fifo_rden;
    #1;
    if (rden_cap != 2'b00) begin
      chk("rden_onehot", (rden_cap == 2'b01) || (rden_cap == 2'b10), 1'b1);
    end
    if (rden_cap[0]) begin
      chk("rden0_nonempty", fq0.size() != 0, 1'b1);
      if (fq0.size() != 0) void'(fq0.pop_front());
    end
    if (rden_cap[1]) begin
      chk("rden1_nonempty", fq1.size() != 0, 1'b1);
      if (fq1.size() != 0) void'(fq1.pop_front());
    end
    refresh_fifo();
  end

  // Output side: scoreboard accepted beats and check stability while stalled.
  always @(negedge clk) begin
    cyc++;
    if (fifo_rden[0]) rden0_cnt++;
    if (fifo_rden[1]) rden1_cnt++;
    if (!rstn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("axis_hold", {tvalid, tdata, tdest, tlast}, {1'b1, prev_beat});
      if (tvalid && tready) begin
        hs_count++;
        if (hs_count == hs_mark + 1) first_hs = cyc;
        last_hs = cyc;
        if (sb_en) begin
          checks++;
          assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_beat: got %0h want none", {tdata, tdest, tlast});
          end
          if (exp_q.size() != 0) chk("beat", {tdata, tdest, tlast}, exp_q.pop_front());
        end
      end
      prev_stall = tvalid && !tready;
      prev_beat  = {tdata, tdest, tlast};
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    int base, base0, base1, n;
    rstn = 1'b1; chan_en = 2'b00; cfg_pkt_len = 16'd4; tready = 1'b0;
    refresh_fifo();
    #1 rstn = 1'b0;
    #2;
    chk("rst_tvalid", tvalid, 1'b0);
    chk("rst_rden", fifo_rden, 2'b00);
    chk("rst_tlast", tlast, 1'b0);
    chk("rst_tdata", tdata, 32'h0);
    chk("rst_tdest", tdest, 4'h0);
    chk("rst_busy", busy, 1'b0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    step();

    // single channel, latency of first word
    chan_en = 2'b11; cfg_pkt_len = 16'd4; tready = 1'b1;
    add(1, 4, 1); schedule(4, 2'b11); refresh_fifo();
    @(posedge clk); @(negedge clk);
    chk("t1_first_pop", fifo_rden, 2'b10);
    chk("t1_no_early_valid", tvalid, 1'b0);
    @(negedge clk);
    chk("t1_valid_latency", tvalid, 1'b1);
    chk("t1_tdest", tdest, 4'h1);
    drain(50);

    // both channels, alternating packets with one bubble between them
    hs_mark = hs_count;
    add(0, 8, 1); add(1, 8, 1); schedule(4, 2'b11); refresh_fifo();
    drain(100);
    chk("t2_beats", hs_count - hs_mark, 16);
    chk("t2_span", last_hs - first_hs, 18);

    // random backpressure
    cfg_pkt_len = 16'd3;
    add(0, 6, 1); add(1, 6, 1); schedule(3, 2'b11); refresh_fifo();
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    tready = 1'b1;
    drain(50);

    // granted FIFO runs dry mid-packet
    cfg_pkt_len = 16'd4;
    add(0, 2, 1); add(0, 2, 0); add(1, 4, 1); schedule(4, 2'b11); refresh_fifo();
    base = hs_count; base1 = rden1_cnt;
    repeat (12) step();
    chk("t4_beats_before_stall", hs_count - base, 2);
    chk("t4_ch1_not_popped", rden1_cnt - base1, 0);
    chk("t4_stalled_tvalid", tvalid, 1'b0);
    chk("t4_busy_stall", busy, 1'b1);
    while (hold0.size() != 0) fq0.push_back(hold0.pop_front());
    refresh_fifo();
    drain(60);

    // zero length means one word; ch0 disabled
    chan_en = 2'b10; cfg_pkt_len = 16'd0;
    base0 = rden0_cnt;
    add(0, 3, 1); add(1, 3, 1); schedule(0, 2'b10); m0.delete(); refresh_fifo();
    drain(60);
    chk("t5_ch0_untouched", fq0.size(), 3);
    chk("t5_ch0_no_rden", rden0_cnt - base0, 0);

    // reset in the middle of a ch0 packet
    fq0.delete(); refresh_fifo();
    chan_en = 2'b11; cfg_pkt_len = 16'd4;
    add(0, 4, 1); add(1, 4, 1); schedule(4, 2'b11); refresh_fifo();
    base = hs_count; n = 0;
    while (hs_count - base < 2 && n < 50) begin
      step();
      n++;
    end
    chk("t6_reached_mid", hs_count - base >= 2, 1'b1);
    sb_en = 1'b0;
    rstn = 1'b0;
    #1;
    chk("t6_rst_tvalid", tvalid, 1'b0);
    chk("t6_rst_rden", fifo_rden, 2'b00);
    chk("t6_rst_busy", busy, 1'b0);
    #1;
    fq0.delete(); fq1.delete(); exp_q.delete(); m0.delete(); m1.delete();
    model_ptr = 0;
    refresh_fifo();
    repeat (2) step();
    rstn = 1'b1; sb_en = 1'b1;
    add(1, 4, 1); add(0, 4, 1); schedule(4, 2'b11); refresh_fifo();
    @(posedge clk); @(negedge clk);
    chk("t6_grant_ch0", fifo_rden, 2'b01);
    drain(60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
